// File: rtl/stereo_debug_pkg.sv
// Shared types for the stereo debug raster path.
// FRAME_COORD_GEN_DECIMATE_EN selects 2:1 input decimation.
package stereo_debug_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int ERR_LONG  = 0;
    localparam int ERR_SHORT = 1;

    typedef logic [9:0] coord_t;

    localparam coord_t COORD_MAX = 10'd1023;

`ifdef FRAME_COORD_GEN_DECIMATE_EN
    localparam int DEC_SHIFT = 1;
`else
    localparam int DEC_SHIFT = 0;
`endif

    // Input-side dimension for an output dimension.
    function automatic logic [10:0] in_dim(input int sz);
        return 11'(sz << DEC_SHIFT);
    endfunction

endpackage

// File: rtl/frame_coord_gen_if.sv
// Pixel stream bundle: one beat per cycle, no backpressure.
// master drives the stream, slave observes it.
interface frame_coord_gen_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_sof;
    logic       s_eol;

    modport master (output s_valid, s_data, s_sof, s_eol);
    modport slave  (input  s_valid, s_data, s_sof, s_eol);

endinterface

// File: rtl/raster_counter.sv
// Input raster position tracker: ix/iy, saturation,
// end-of-line wrap and end-of-frame detect.
module raster_counter
    import stereo_debug_pkg::*;
#(
    parameter int COL_SZ = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_active,
    frame_coord_gen_if.slave  pix,
    output logic              o_take,
    output coord_t            o_x,
    output coord_t            o_y,
    output logic              o_eol,
    output logic              o_eof
);

    localparam logic [10:0] IN_H = in_dim(COL_SZ);

    coord_t r_ix;
    coord_t r_iy;
    coord_t w_ix_nxt;
    coord_t w_iy_nxt;

    // Position of the current beat and the counter update.
    always_comb begin
        o_take   = pix.s_valid & (pix.s_sof | i_active);
        o_x      = pix.s_sof ? '0 : r_ix;
        o_y      = pix.s_sof ? '0 : r_iy;
        o_eol    = o_take & pix.s_eol;
        o_eof    = o_eol & (({1'b0, o_y} + 11'd1) == IN_H);
        w_ix_nxt = r_ix;
        w_iy_nxt = r_iy;
        if (o_take) begin
            if (pix.s_eol) begin
                w_ix_nxt = '0;
                w_iy_nxt = o_y + 10'd1;
            end else begin
                w_ix_nxt = (o_x == COORD_MAX) ? o_x : o_x + 10'd1;
                w_iy_nxt = o_y;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ix <= '0;
            r_iy <= '0;
        end else begin
            r_ix <= w_ix_nxt;
            r_iy <= w_iy_nxt;
        end
    end

endmodule

// File: rtl/frame_coord_gen.sv
// Raster coordinate generator for the stereo debug frame buffer.
// FRAME_COORD_GEN_DECIMATE_EN: 2x input, keep even pixels of even lines.
module frame_coord_gen
    import stereo_debug_pkg::*;
#(
    parameter int ROW_SZ = 320,
    parameter int COL_SZ = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    input  logic        err_clr,
    output coord_t      out_x,
    output coord_t      out_y,
    output logic [7:0]  out_val,
    output logic        out_is_val,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [1:0]  err
);

    localparam logic [10:0] IN_W   = in_dim(ROW_SZ);
    localparam logic [10:0] IN_H   = in_dim(COL_SZ);
    localparam logic [10:0] IN_WM1 = IN_W - 11'd1;

    frame_coord_gen_if w_pix ();

    assign w_pix.s_valid = s_valid;
    assign w_pix.s_data  = s_data;
    assign w_pix.s_sof   = s_sof;
    assign w_pix.s_eol   = s_eol;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_take;
    logic       w_eol;
    logic       w_eof;
    coord_t     w_x;
    coord_t     w_y;
    coord_t     w_ox;
    coord_t     w_oy;
    logic       w_in_win;
    logic       w_keep;
    logic       w_emit;
    logic [1:0] w_err_set;

    raster_counter #(
        .COL_SZ (COL_SZ)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_active (r_state == ACTIVE),
        .pix      (w_pix),
        .o_take   (w_take),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_eol    (w_eol),
        .o_eof    (w_eof)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: sof (re)starts a frame, frame end wins over it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_take && w_pix.s_sof) w_state_nxt = ACTIVE;
        if (w_eof)                 w_state_nxt = IDLE;
    end

    // Clipping, output mapping and error detection.
    always_comb begin
        w_in_win = ({1'b0, w_x} < IN_W) && ({1'b0, w_y} < IN_H);
`ifdef FRAME_COORD_GEN_DECIMATE_EN
        w_keep   = ~w_x[0] & ~w_y[0];
        w_ox     = w_x >> 1;
        w_oy     = w_y >> 1;
`else
        w_keep   = 1'b1;
        w_ox     = w_x;
        w_oy     = w_y;
`endif
        w_emit   = w_take & w_in_win & w_keep;
        w_err_set            = '0;
        w_err_set[ERR_LONG]  = w_take & ({1'b0, w_x} >= IN_W);
        w_err_set[ERR_SHORT] = w_eol & ({1'b0, w_x} < IN_WM1);
    end

    // Registered write stream and status; a new error beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_x      <= '0;
            out_y      <= '0;
            out_val    <= '0;
            out_is_val <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= '0;
        end else begin
            out_is_val <= w_emit;
            frame_done <= w_eof;
            if (w_emit) begin
                out_x   <= w_ox;
                out_y   <= w_oy;
                out_val <= w_pix.s_data;
            end
            if (w_eof) frame_cnt <= frame_cnt + 16'd1;
            err <= (err & ~{2{err_clr}}) | w_err_set;
        end
    end

endmodule

// File: tb/tb_frame_coord_gen.sv
// Scoreboard bench for frame_coord_gen on a 32x16 raster.
// Directed frames: clean, long line, short line, sof restart, reset.
module tb_frame_coord_gen;

    localparam int RW = 32;
    localparam int CH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        err_clr = 1'b0;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic [7:0]  out_val;
    logic        out_is_val;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [1:0]  err;

    frame_coord_gen_if bus ();

    frame_coord_gen #(
        .ROW_SZ (RW),
        .COL_SZ (CH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (bus.s_valid),
        .s_data     (bus.s_data),
        .s_sof      (bus.s_sof),
        .s_eol      (bus.s_eol),
        .err_clr    (err_clr),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_val    (out_val),
        .out_is_val (out_is_val),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int last_x = -1;
    int last_y = -1;
    logic [27:0] exp_q[$];

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'((x * 5) + (y * 17) + 1);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic beat(input logic sof, input logic eol,
                        input logic clr, input logic [7:0] d,
                        input logic emit, input int x, input int y);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        bus.s_data  = d;
        err_clr     = clr;
        if (emit) exp_q.push_back({10'(x), 10'(y), d});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.s_sof   = 1'b0;
            bus.s_eol   = 1'b0;
            err_clr     = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.s_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        idle(1);
    endtask

    task automatic line(input int y, input int n, input logic sof);
        for (int x = 0; x < n; x++)
            beat(sof && x == 0, x == n - 1, 1'b0, pix(x, y),
                 x < RW, x, y);
    endtask

    task automatic frame_rest(input int y0);
        for (int y = y0; y < CH; y++) line(y, RW, 1'b0);
    endtask

    // Monitor: pop and compare on every write strobe.
    initial begin
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (frame_done) done_seen++;
            if (out_is_val) begin
                tests++;
                last_x = int'(out_x);
                last_y = int'(out_y);
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stray_write: got (%0d,%0d)=%0d required none",
                             out_x, out_y, out_val);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_x, out_y, out_val} !== e) begin
                        fails++;
                        $display("FAIL write: got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                                 out_x, out_y, out_val,
                                 e[27:18], e[17:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_is_val", int'(out_is_val), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b1;
        idle(2);

        // Pixels before any sof are discarded without error.
        for (int i = 0; i < 5; i++)
            beat(1'b0, i == 4, 1'b0, 8'hAA, 1'b0, 0, 0);
        idle(2);
        chk("idle_err", int'(err), 0);

        // Clean frame.
        line(0, RW, 1'b1);
        frame_rest(1);
        idle(2);
        chk("A_frame_cnt", int'(frame_cnt), 1);
        chk("A_done", done_seen, 1);
        chk("A_err", int'(err), 0);
        chk("A_last_x", last_x, RW - 1);
        chk("A_last_y", last_y, CH - 1);

        // First line 5 pixels too long.
        line(0, RW + 5, 1'b1);
        idle(2);
        chk("B_err_long", int'(err), 1);
        frame_rest(1);
        idle(2);
        chk("B_frame_cnt", int'(frame_cnt), 2);
        clr_pulse();
        chk("B_err_clr", int'(err), 0);

        // Short line, then sof restart mid-frame.
        line(0, RW, 1'b1);
        line(1, 11, 1'b0);
        idle(2);
        chk("C_err_short", int'(err), 2);
        clr_pulse();
        chk("C_err_clr", int'(err), 0);
        line(2, RW, 1'b0);
        line(3, RW, 1'b0);
        line(4, RW, 1'b0);
        line(0, RW, 1'b1);
        idle(2);
        chk("C_no_done", done_seen, 2);
        frame_rest(1);
        idle(2);
        chk("C_frame_cnt", int'(frame_cnt), 3);
        chk("C_done", done_seen, 3);
        chk("C_err", int'(err), 0);

        // sof+eol on one beat; err_clr racing a new error.
        beat(1'b1, 1'b1, 1'b0, pix(0, 0), 1'b1, 0, 0);
        idle(2);
        chk("D_sofeol_err", int'(err), 2);
        chk("D_sofeol_y", last_y, 0);
        clr_pulse();
        chk("D_err_clr", int'(err), 0);
        for (int x = 0; x <= RW; x++)
            beat(1'b0, x == RW, x == RW, pix(x, 1), x < RW, x, 1);
        idle(2);
        chk("D_clr_vs_err", int'(err), 1);
        frame_rest(2);
        idle(2);
        chk("D_frame_cnt", int'(frame_cnt), 4);
        clr_pulse();

        // Reset in the middle of a frame.
        line(0, RW, 1'b1);
        line(1, RW, 1'b0);
        line(2, 7, 1'b0);
        idle(2);
        chk("E_err_pre", int'(err), 2);
        reset = 1'b0;
        #1;
        chk("E_rst_x", int'(out_x), 0);
        chk("E_rst_y", int'(out_y), 0);
        chk("E_rst_val", int'(out_val), 0);
        chk("E_rst_cnt", int'(frame_cnt), 0);
        chk("E_rst_err", int'(err), 0);
        idle(2);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 40; i++)
            beat(1'b0, i == RW - 1, 1'b0, pix(i, 3), 1'b0, 0, 0);
        idle(3);
        chk("E_done", done_seen, 4);
        chk("E_frame_cnt", int'(frame_cnt), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
